// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, flag indices and types for the fp32 add/sub datapath
package fp_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_INF = 255;
    localparam int MAN_W   = 28;
    localparam int FRAC_W  = 23;
    localparam int EXP_W   = 8;
    localparam int EXP_IW  = 9;

    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of {hidden, frac} using guard/round/sticky
module fp_round_rne
    import fp_pkg::*;
(
    input  logic              hidden,
    input  logic [FRAC_W-1:0] frac,
    input  logic              guard,
    input  logic              round,
    input  logic              sticky,
    output logic              hidden_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              carry,
    output logic              inexact
);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    assign inc     = guard & (round | sticky | frac[0]);
    assign sum     = {1'b0, hidden, frac} + {{(FRAC_W+1){1'b0}}, inc};
    assign inexact = guard | round | sticky;

    // On carry-out the sum is exactly 2.0, so the low bits are already zero
    // and the mantissa reads back as 1.0 once the exponent is bumped.
    assign carry      = sum[FRAC_W+1];
    assign hidden_out = sum[FRAC_W+1] | sum[FRAC_W];
    assign frac_out   = sum[FRAC_W-1:0];

endmodule

// File: rtl/fp_normalize_pack.sv
// rtl/fp_normalize_pack.sv - iterative normalize, RNE round and IEEE-754 pack of the adder sum
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MAN_W-1:0]  in_man,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_val,
    output logic [3:0]        out_flags
);

    norm_state_t       state;
    norm_state_t       state_next;

    logic              sign_r;
    logic [EXP_IW-1:0] exp_r;
    logic [MAN_W-1:0]  man_r;
    logic [31:0]       val_r;
    logic [3:0]        flags_r;

    logic              man_zero;
    logic              carry_bit;
    logic              hidden_bit;
    logic              shift_left;

    logic              rnd_hidden;
    logic [FRAC_W-1:0] rnd_frac;
    logic              rnd_carry;
    logic              rnd_inexact;
    logic [EXP_IW-1:0] exp_rnd;
    fp32_t             pack_val;
    logic [3:0]        pack_flags;

    assign man_zero   = (man_r == '0);
    assign carry_bit  = man_r[MAN_W-1];
    assign hidden_bit = man_r[MAN_W-2];
    assign shift_left = !carry_bit && !man_zero && !hidden_bit && (exp_r > 9'd1);

    assign in_ready  = reset && (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_val   = val_r;
    assign out_flags = flags_r;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = NORM;
            NORM:    if (!shift_left) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    fp_round_rne u_round (
        .hidden     (hidden_bit),
        .frac       (man_r[FRAC_W+2:3]),
        .guard      (man_r[2]),
        .round      (man_r[1]),
        .sticky     (man_r[0]),
        .hidden_out (rnd_hidden),
        .frac_out   (rnd_frac),
        .carry      (rnd_carry),
        .inexact    (rnd_inexact)
    );

    assign exp_rnd = exp_r + {{(EXP_IW-1){1'b0}}, rnd_carry};

    always_comb begin
        pack_val   = '0;
        pack_flags = '0;
        if (man_zero) begin
            pack_flags[FLAG_ZERO] = 1'b1;
        end else if (rnd_hidden) begin
            pack_val.sign = sign_r;
            if (exp_rnd >= 9'(EXP_INF)) begin
                pack_val.exp                = '1;
                pack_flags[FLAG_OVERFLOW]   = 1'b1;
                pack_flags[FLAG_INEXACT]    = 1'b1;
            end else begin
                pack_val.exp             = exp_rnd[EXP_W-1:0];
                pack_val.frac            = rnd_frac;
                pack_flags[FLAG_INEXACT] = rnd_inexact;
            end
        end else begin
            // Denormal: exponent field is zero, fraction holds the scaled value.
            pack_val.sign              = sign_r;
            pack_val.frac              = rnd_frac;
            pack_flags[FLAG_UNDERFLOW] = rnd_inexact;
            pack_flags[FLAG_INEXACT]   = rnd_inexact;
            pack_flags[FLAG_ZERO]      = (rnd_frac == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            man_r   <= '0;
            val_r   <= '0;
            flags_r <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        exp_r  <= {1'b0, in_exp};
                        man_r  <= in_man;
                    end
                end
                NORM: begin
                    if (carry_bit) begin
                        man_r <= {1'b0, man_r[MAN_W-1:2], man_r[1] | man_r[0]};
                        exp_r <= exp_r + 9'd1;
                    end else if (shift_left) begin
                        man_r <= {man_r[MAN_W-2:0], 1'b0};
                        exp_r <= exp_r - 9'd1;
                    end
                end
                ROUND: begin
                    val_r   <= pack_val;
                    flags_r <= pack_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb/tb_fp_normalize_pack.sv - randomized scoreboard bench for fp_normalize_pack
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_val;
    logic [3:0]  out_flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 1;
    bit seen = 0;

    typedef struct {
        logic [31:0] val;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t q[$];

    fp_normalize_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: treat the mantissa as an integer, normalize, then round by remainder.
    function automatic void model(input logic s, input logic [7:0] e_in, input logic [27:0] m_in,
                                  output logic [31:0] v, output logic [3:0] f, output int l);
        longint m;
        longint keep;
        int     e;
        int     rem;
        bit     inx;
        bit     up;
        l = 0;
        v = 32'h0;
        f = 4'h0;
        if (m_in == 28'h0) begin
            f = 4'b0010;
            return;
        end
        m = longint'(m_in);
        e = int'(e_in);
        if (m >= 64'd134217728) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else begin
            while (m < 64'd67108864 && e > 1) begin
                m = m * 2;
                e = e - 1;
                l = l + 1;
            end
        end
        keep = m / 8;
        rem  = int'(m % 8);
        inx  = (rem != 0);
        up   = (rem > 4) || (rem == 4 && (keep % 2) == 1);
        keep = keep + longint'(up);
        if (keep == 64'd16777216) begin
            keep = 64'd8388608;
            e = e + 1;
        end
        if (keep >= 64'd8388608) begin
            if (e >= 255) begin
                v = {s, 31'h7F800000};
                f = 4'b1001;
            end else begin
                v = {s, 8'(e), 23'(keep)};
                f = {3'b000, inx};
            end
        end else begin
            v = {s, 8'h00, 23'(keep)};
            f = {1'b0, inx, keep == 0, inx};
        end
    endfunction

    task automatic pin(input string name, input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [31:0] ev, input logic [3:0] ef, input int el);
        logic [31:0] v;
        logic [3:0]  f;
        int          l;
        model(s, e, m, v, f, l);
        checks++;
        if (v !== ev || f !== ef || l != el) begin
            errors++;
            $display("FAIL model_%s: got val=%h flags=%b shifts=%0d, expected val=%h flags=%b shifts=%0d",
                     name, v, f, l, ev, ef, el);
        end
    endtask

    // Scoreboard: check every cycle out_valid is high, including stalls.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: out_valid=1 with nothing outstanding, val=%h", out_val);
            end else begin
                checks++;
                if (out_val !== q[0].val || out_flags !== q[0].flags) begin
                    errors++;
                    $display("FAIL result: got val=%h flags=%b, expected val=%h flags=%b",
                             out_val, out_flags, q[0].val, q[0].flags);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_done: in_ready=%b, expected 0", in_ready);
                end
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (cyc != q[0].due) begin
                        errors++;
                        $display("FAIL latency: out_valid at cycle %0d, expected cycle %0d", cyc, q[0].due);
                    end
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
        exp_t x;
        int   l;
        int   n;
        model(s, e, m, x.val, x.flags, l);
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        x.due = cyc + 1 + 2 + l;
        q.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_man   = 28'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
            seen = 0;
        end
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [27:0] m;
        logic [7:0]  e;
        int          n;

        reset = 1'b0;
        in_valid = 1'b0;
        in_sign = 1'b0;
        in_exp = 8'h0;
        in_man = 28'h0;
        out_ready = 1'b1;

        pin("one_plus_one", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 4'b0000, 0);
        pin("cancel",       1'b1, 8'd130, 28'h0000000, 32'h00000000, 4'b0010, 0);
        pin("left_norm",    1'b0, 8'd127, 28'h1000000, 32'h3E800000, 4'b0000, 2);
        pin("tie_even",     1'b0, 8'd127, 28'h4000004, 32'h3F800000, 4'b0001, 0);
        pin("tie_odd",      1'b0, 8'd127, 28'h400000C, 32'h3F800002, 4'b0001, 0);
        pin("overflow",     1'b0, 8'd254, 28'h8000000, 32'h7F800000, 4'b1001, 0);
        pin("denormal",     1'b0, 8'd1,   28'h0000010, 32'h00000002, 4'b0000, 0);
        pin("denorm_zero",  1'b1, 8'd1,   28'h0000001, 32'h80000000, 4'b0111, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_val !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b val=%h flags=%b in_ready=%b, expected 0 0 0 0",
                     out_valid, out_val, out_flags, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        rdy_mode = 1;
        send(1'b0, 8'd127, 28'h8000000);
        send(1'b1, 8'd130, 28'h0000000);
        send(1'b0, 8'd127, 28'h1000000);
        send(1'b0, 8'd127, 28'h4000004);
        send(1'b0, 8'd127, 28'h400000C);
        send(1'b0, 8'd254, 28'h8000000);
        send(1'b0, 8'd1,   28'h0000010);
        send(1'b1, 8'd1,   28'h0000001);
        send(1'b0, 8'd200, 28'h0000001);
        send(1'b1, 8'd100, 28'h7FFFFFC);
        wait_drain();

        rdy_mode = 2;
        send(1'b1, 8'd100, 28'h5A5A5A5);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = out_val;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_val !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall: valid=%b val=%h in_ready=%b, expected 1 %h 0",
                         out_valid, out_val, in_ready, held);
            end
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain();

        send(1'b0, 8'd30, 28'h0000008);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        seen = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_norm: valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b valid=%b, expected 1 0", in_ready, out_valid);
        end
        repeat (40) @(posedge clk);
        #1;

        rdy_mode = 0;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 5))
                0:       m = 28'h0;
                1:       m = {1'b1, 27'($urandom)};
                2:       m = {2'b01, 26'($urandom)};
                3:       m = 28'($urandom) >> $urandom_range(0, 27);
                4:       m = {2'b01, 23'h7FFFFF, 3'($urandom)};
                default: m = 28'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(1, 3));
                1:       e = 8'($urandom_range(252, 255));
                default: e = 8'($urandom_range(1, 254));
            endcase
            if (m == 28'h0) e = 8'($urandom);
            send(1'($urandom), e, m);
        end
        rdy_mode = 1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
